// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: display > fill engine > host
module vram_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 16,
  parameter int FB_WORDS = 120000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_A, TAG_B} tag_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] fill_addr, fill_addr_nxt;
  logic [DATA_W-1:0] fill_word, fill_word_nxt;
  logic              fill_issue;
  logic              b_issue;
  tag_t              tag_s1, tag_s2;

  // Host is locked out for the whole fill, including the DONE cycle.
  assign b_ready   = !rst && !a_req && (state == IDLE);
  assign b_issue   = b_valid && b_ready;
  assign fill_busy = (state != IDLE);
  assign fill_done = (state == DONE);

  always_comb begin
    state_nxt     = state;
    fill_addr_nxt = fill_addr;
    fill_word_nxt = fill_word;
    fill_issue    = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          fill_word_nxt = fill_value;
          fill_addr_nxt = '0;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        if (!a_req) begin
          fill_issue    = 1'b1;
          fill_addr_nxt = fill_addr + ADDR_W'(1);
          if (fill_addr == LAST_ADDR) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      fill_addr <= '0;
      fill_word <= '0;
    end else begin
      state     <= state_nxt;
      fill_addr <= fill_addr_nxt;
      fill_word <= fill_word_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag_s1    <= TAG_NONE;
      tag_s2    <= TAG_NONE;
    end else begin
      ram_en <= a_req || fill_issue || b_issue;
      ram_we <= fill_issue || (b_issue && b_we);
      if (a_req) begin
        ram_addr <= a_addr;
      end else if (fill_issue) begin
        ram_addr  <= fill_addr;
        ram_wdata <= fill_word;
      end else if (b_issue) begin
        ram_addr <= b_addr;
        if (b_we) ram_wdata <= b_wdata;
      end
      // Tag follows each read so the returning word goes to its requester.
      if (a_req)                tag_s1 <= TAG_A;
      else if (b_issue && !b_we) tag_s1 <= TAG_B;
      else                      tag_s1 <= TAG_NONE;
      tag_s2 <= tag_s1;
    end
  end

  assign a_rvalid = (tag_s2 == TAG_A);
  assign b_rvalid = (tag_s2 == TAG_B);
  assign a_rdata  = rst ? '0 : ram_rdata;
  assign b_rdata  = rst ? '0 : ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed vector bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req;
  logic [16:0] a_addr;
  logic        a_rvalid;
  logic [15:0] a_rdata;
  logic        b_valid;
  logic        b_we;
  logic [16:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_ready;
  logic        b_rvalid;
  logic [15:0] b_rdata;
  logic        fill_start;
  logic [15:0] fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic        ram_en;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;

  logic [15:0] mem [0:1023];
  int total = 0;
  int bad   = 0;

  vram_arbiter #(.ADDR_W(17), .DATA_W(16), .FB_WORDS(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .fill_start(fill_start), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[9:0]];
    end
  end

  typedef struct {
    logic        a_req;
    logic [16:0] a_addr;
    logic        b_valid;
    logic        b_we;
    logic [16:0] b_addr;
    logic [15:0] b_wdata;
    logic        x_ready;
    logic        x_en;
    logic        x_we;
    logic [16:0] x_addr;
    logic [15:0] x_wdata;
    logic        x_av;
    logic        x_bv;
    logic [15:0] x_data;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic ar, logic [16:0] aa, logic bv, logic bw,
                              logic [16:0] ba, logic [15:0] bd, logic xr,
                              logic xe, logic xw, logic [16:0] xa, logic [15:0] xd,
                              logic xav, logic xbv, logic [15:0] xdat);
    vec_t v;
    v.a_req = ar;  v.a_addr = aa;  v.b_valid = bv; v.b_we = bw;
    v.b_addr = ba; v.b_wdata = bd; v.x_ready = xr; v.x_en = xe;
    v.x_we = xw;   v.x_addr = xa;  v.x_wdata = xd; v.x_av = xav;
    v.x_bv = xbv;  v.x_data = xdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_req = 0; a_addr = '0; b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    fill_start = 0; fill_value = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_rvalid"}, 32'(a_rvalid), 0);
    check({tag, "_a_rdata"},  32'(a_rdata), 0);
    check({tag, "_b_rvalid"}, 32'(b_rvalid), 0);
    check({tag, "_b_rdata"},  32'(b_rdata), 0);
    check({tag, "_b_ready"},  32'(b_ready), 0);
    check({tag, "_fill_busy"}, 32'(fill_busy), 0);
    check({tag, "_fill_done"}, 32'(fill_done), 0);
    check({tag, "_ram_en"},   32'(ram_en), 0);
    check({tag, "_ram_we"},   32'(ram_we), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
  endtask

  // Runs from the first RUN cycle until the 16th fill write, then one idle cycle.
  task automatic run_fill(input logic [15:0] val, input bit use_a, input bit pulse_again);
    int k;
    logic [16:0] exp_addr;
    bit areq;
    k = 0;
    exp_addr = '0;
    while (exp_addr < 17'd16 && k < 64) begin
      areq = use_a && (k % 4 == 3);
      idle_inputs();
      a_req = areq;
      a_addr = 17'h20;
      fill_start = pulse_again && (k == 0);
      fill_value = 16'h7777;
      #1;
      check("fill_b_ready", 32'(b_ready), 0);
      check("fill_busy", 32'(fill_busy), 1);
      @(posedge clk); #1;
      if (areq) begin
        check("fill_a_en", 32'(ram_en), 1);
        check("fill_a_we", 32'(ram_we), 0);
        check("fill_a_addr", 32'(ram_addr), 32'h20);
      end else begin
        check("fill_we", 32'(ram_we), 1);
        check("fill_addr", 32'(ram_addr), 32'(exp_addr));
        check("fill_wdata", 32'(ram_wdata), 32'(val));
        exp_addr++;
      end
      check("fill_done_timing", 32'(fill_done), 32'(exp_addr == 17'd16));
      k++;
    end
    if (k >= 64) begin
      total++; bad++;
      $display("FAIL fill_timeout: got %0d writes expected 16", exp_addr);
    end
    idle_inputs();
    step();
    check("fill_done_pulse", 32'(fill_done), 0);
    check("fill_busy_end", 32'(fill_busy), 0);
    check("fill_ready_end", 32'(b_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  who  [12];
    logic [16:0] iadr [12];
    for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 | 16'(i);

    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, 17'h10 + 17'(i), 1, 0, 17'h100, 0, 0,
                   1, 0, 17'h10 + 17'(i), 0, i > 0, 0, 16'hC00F + 16'(i));
    vecs[8]  = mk(0, 0, 1, 0, 17'h100, 0, 1, 1, 0, 17'h100, 0, 1, 0, 16'hC017);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 17'h100, 0, 0, 1, 16'hC100);
    vecs[10] = mk(0, 0, 1, 1, 17'h5, 16'h1234, 1, 1, 1, 17'h5, 16'h1234, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 0, 17'h5, 0, 1, 1, 0, 17'h5, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 17'h5, 0, 0, 1, 16'h1234);

    // Reset state
    idle_inputs();
    rst = 1;
    step(); step();
    check_all_zero("reset");
    rst = 0;

    // Vector table: contention, then host write/read
    for (int i = 0; i < 13; i++) begin
      a_req = vecs[i].a_req;   a_addr = vecs[i].a_addr;
      b_valid = vecs[i].b_valid; b_we = vecs[i].b_we;
      b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      fill_start = 0; fill_value = '0;
      #1;
      check($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].x_ready));
      step();
      check($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vecs[i].x_en));
      check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].x_we));
      check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].x_addr));
      if (vecs[i].x_en && vecs[i].x_we)
        check($sformatf("v%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].x_wdata));
      check($sformatf("v%0d_a_rvalid", i), 32'(a_rvalid), 32'(vecs[i].x_av));
      check($sformatf("v%0d_b_rvalid", i), 32'(b_rvalid), 32'(vecs[i].x_bv));
      if (vecs[i].x_av) check($sformatf("v%0d_a_rdata", i), 32'(a_rdata), 32'(vecs[i].x_data));
      if (vecs[i].x_bv) check($sformatf("v%0d_b_rdata", i), 32'(b_rdata), 32'(vecs[i].x_data));
    end

    // Fill with display reads interleaved
    idle_inputs();
    fill_start = 1; fill_value = 16'hA5A5;
    step();
    check("fill_start_busy", 32'(fill_busy), 1);
    check("fill_start_en", 32'(ram_en), 0);
    run_fill(16'hA5A5, 1, 0);
    for (int i = 0; i < 16; i++) check($sformatf("fill_mem%0d", i), 32'(mem[i]), 32'hA5A5);

    // fill_start together with accepted host write; second start ignored
    idle_inputs();
    fill_start = 1; fill_value = 16'h5555;
    b_valid = 1; b_we = 1; b_addr = 17'h3; b_wdata = 16'hBEEF;
    #1;
    check("same_b_ready", 32'(b_ready), 1);
    step();
    check("same_host_we", 32'(ram_we), 1);
    check("same_host_addr", 32'(ram_addr), 3);
    check("same_host_wdata", 32'(ram_wdata), 32'hBEEF);
    check("same_busy", 32'(fill_busy), 1);
    run_fill(16'h5555, 0, 1);
    check("same_mem3", 32'(mem[3]), 32'h5555);

    // Asynchronous reset mid-fill with reads in flight
    idle_inputs();
    fill_start = 1; fill_value = 16'h2222;
    step();
    idle_inputs();
    step(); step(); step();
    a_req = 1; a_addr = 17'h11;
    step();
    a_addr = 17'h12;
    step();
    idle_inputs();
    rst = 1;
    #1;
    check_all_zero("async_rst");
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_a_rvalid", 32'(a_rvalid), 0);
      check("post_rst_b_rvalid", 32'(b_rvalid), 0);
      check("post_rst_fill_done", 32'(fill_done), 0);
      check("post_rst_fill_busy", 32'(fill_busy), 0);
    end
    fill_start = 1; fill_value = 16'h1111;
    step();
    run_fill(16'h1111, 0, 0);

    // Alternating A and B reads: tags never swapped, fixed latency
    for (int k = 0; k < 13; k++) begin
      idle_inputs();
      if (k < 12) begin
        if (k % 2 == 0) begin
          a_req = 1; a_addr = 17'h30 + 17'(k);
          who[k] = 2'd1; iadr[k] = a_addr;
        end else begin
          b_valid = 1; b_addr = 17'h140 + 17'(k);
          who[k] = 2'd2; iadr[k] = b_addr;
          #1;
          check("alt_b_ready", 32'(b_ready), 1);
        end
      end
      step();
      check("alt_overlap", 32'(a_rvalid && b_rvalid), 0);
      if (k >= 1) begin
        check("alt_a_rvalid", 32'(a_rvalid), 32'(who[k-1] == 2'd1));
        check("alt_b_rvalid", 32'(b_rvalid), 32'(who[k-1] == 2'd2));
        if (who[k-1] == 2'd1)
          check("alt_a_rdata", 32'(a_rdata), 32'(16'hC000 | {6'd0, iadr[k-1][9:0]}));
        else
          check("alt_b_rdata", 32'(b_rdata), 32'(16'hC000 | {6'd0, iadr[k-1][9:0]}));
      end
    end
    step();
    check("alt_tail_a", 32'(a_rvalid), 0);
    check("alt_tail_b", 32'(b_rvalid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
